adc_reader: RTL and testbench

Master-side controller for the ADS7883-style serial ADC used on the badge. It drives chip-select and the serial clock, shifts in one leading zero plus a 12-bit MSB-first sample, and presents each sample to the waterfall datapath with a one-cycle valid strobe. It sits between the ADC pins and the sample FIFO/FFT front end. It runs single-shot on `start` or back-to-back when `free_run` is high.

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_reader_if.sv | 25 ++
 rtl/adc_sclk_gen.sv | 40 ++++
 rtl/adc_reader.sv | 111 +++++++++++
 tb/tb_adc_reader.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// adc_reader shared types and defaults.
// Serial ADC front end for the badge waterfall.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_QUIET
  } state_t;

  localparam int ADC_WIDTH = 12;
  localparam int ADC_LEAD  = 1;

endpackage

// File: rtl/adc_reader_if.sv
// Pin and sample bus of adc_reader.
// master = reader, slave = ADC pins plus datapath side.
interface adc_reader_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic             free_run;
  logic             sd;
  logic             cs;
  logic             sclk;
  logic             busy;
  logic [WIDTH-1:0] sample;
  logic             valid;
  logic             lead_err;

  modport master (
    input  start, free_run, sd,
    output cs, sclk, busy, sample, valid, lead_err
  );

  modport slave (
    output start, free_run, sd,
    input  cs, sclk, busy, sample, valid, lead_err
  );
endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK divider for adc_reader.
// rise/fall flag the edge on which sclk will toggle.
module adc_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  // Half-period counter; sclk rests high whenever cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (clear) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else if (en) begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_reader.sv
// ADS7883-style serial ADC reader.
// Drives cs/sclk, shifts in lead + sample bits.
module adc_reader
  import adc_pkg::*;
#(
  parameter int WIDTH   = ADC_WIDTH,
  parameter int LEAD    = ADC_LEAD,
  parameter int CLK_DIV = 2,
  parameter int QUIET   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  adc_reader_if.master bus
);

  localparam int NB = LEAD + WIDTH;
  localparam int QN = QUIET * 2 * CLK_DIV;
  localparam int BW = $clog2(NB + 1);
  localparam int QW = $clog2(QN + 1);

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [QW-1:0]    q_cnt;
  logic [WIDTH-1:0] shreg;
  logic             lead_flag;
  logic             run;
  logic             clear;
  logic             last;
  logic             rise;
  logic             fall;
  logic             sclk;

  assign run   = (state == ST_SETUP) || (state == ST_SHIFT);
  // Frame ends where the next fall would be: sclk stays high
  assign last  = (state == ST_SHIFT) && fall
               && (bit_cnt == BW'(NB));
  assign clear = !run || last;

  assign bus.sclk = sclk;

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run),
    .clear   (clear),
    .sclk    (sclk),
    .rise    (rise),
    .fall    (fall)
  );

  // Conversion FSM, bit capture and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      q_cnt        <= '0;
      shreg        <= '0;
      lead_flag    <= 1'b0;
      bus.cs       <= 1'b1;
      bus.busy     <= 1'b0;
      bus.valid    <= 1'b0;
      bus.sample   <= '0;
      bus.lead_err <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start || bus.free_run) begin
            state     <= ST_SETUP;
            bus.cs    <= 1'b0;
            bus.busy  <= 1'b1;
            bit_cnt   <= '0;
            shreg     <= '0;
            lead_flag <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (fall) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (last) begin
            state        <= ST_QUIET;
            bus.cs       <= 1'b1;
            bus.valid    <= 1'b1;
            bus.sample   <= shreg;
            bus.lead_err <= lead_flag;
            q_cnt        <= '0;
          end else if (rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < BW'(LEAD))
              lead_flag <= lead_flag | bus.sd;
            else
              shreg <= {shreg[WIDTH-2:0], bus.sd};
          end
        end
        ST_QUIET: begin
          if (q_cnt == QW'(QN - 1)) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else begin
            q_cnt <= q_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_reader.sv
// Self-checking bench for adc_reader.
// Behavioural ADC model plus frame monitor.
module tb_adc_reader;

  localparam int WIDTH   = 12;
  localparam int LEAD    = 1;
  localparam int CLK_DIV = 2;
  localparam int QUIET   = 2;
  localparam int NB      = LEAD + WIDTH;
  localparam int QN      = QUIET * 2 * CLK_DIV;
  localparam int LAT     = CLK_DIV + NB * 2 * CLK_DIV;
  localparam int PERIOD  = 1 + LAT + QN;
  localparam int GAP     = PERIOD - LAT;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             le;
    logic             sclk_hi;
    int               lat;
    int               rises;
    int               falls;
    int               gap;
    int               cyc;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n;

  adc_reader_if #(.WIDTH(WIDTH)) bus ();

  adc_reader #(
    .WIDTH   (WIDTH),
    .LEAD    (LEAD),
    .CLK_DIV (CLK_DIV),
    .QUIET   (QUIET)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [NB-1:0] adc_word = '0;
  logic [NB-1:0] frame    = '0;
  int            bit_i    = 0;
  int            cyc      = 0;
  int            cs_fall  = 0;
  int            cs_rise  = 0;
  int            rises    = 0;
  int            falls    = 0;
  int            gap      = 0;
  int            edges    = 0;
  logic          prev_cs   = 1'b1;
  logic          prev_sclk = 1'b1;
  rec_t          recs[$];

  // ADC pin model and frame monitor, evaluated between clock edges
  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !bus.cs) begin
      frame   = adc_word;
      bit_i   = 0;
      cs_fall = cyc;
      gap     = cyc - cs_rise;
      rises   = 0;
      falls   = 0;
    end
    if (!prev_cs && bus.cs) cs_rise = cyc;
    if (prev_sclk && !bus.sclk) begin
      falls++;
      edges++;
      if (!bus.cs && bit_i < NB) begin
        bus.sd = frame[NB-1-bit_i];
        bit_i++;
      end
    end
    if (!prev_sclk && bus.sclk) begin
      rises++;
      edges++;
    end
    if (bus.valid === 1'b1) begin
      recs.push_back('{s: bus.sample, le: bus.lead_err,
                       sclk_hi: bus.sclk,
                       lat: cyc - cs_fall, rises: rises,
                       falls: falls, gap: gap, cyc: cyc});
    end
    prev_cs   = bus.cs;
    prev_sclk = bus.sclk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
  endtask

  task automatic wait_frame(input string tag, output rec_t r);
    int n;
    n = 0;
    while (recs.size() == 0 && n < 4 * PERIOD) begin
      tick(1);
      n++;
    end
    vectors++;
    assert (recs.size() > 0) else begin
      miscompares++;
      $error("FAIL %s observed=no_valid expected=valid", tag);
    end
    if (recs.size() > 0) r = recs.pop_front();
    else r = '{default: 0};
  endtask

  task automatic chk_frame(input string tag, input rec_t r,
                           input logic [WIDTH-1:0] data,
                           input logic lead);
    chk({tag, ".sample"}, 64'(r.s), 64'(data));
    chk({tag, ".lead_err"}, 64'(r.le), 64'(lead));
    chk({tag, ".latency"}, 64'(r.lat), 64'(LAT));
    chk({tag, ".rises"}, 64'(r.rises), 64'(NB));
    chk({tag, ".falls"}, 64'(r.falls), 64'(NB));
    chk({tag, ".sclk_hi"}, 64'(r.sclk_hi), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t             r;
    rec_t             prev;
    logic [WIDTH-1:0] d;
    logic             ld;
    logic [WIDTH-1:0] exp_q[$];
    int               e0;

    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.free_run = 1'b0;
    tick(3);
    chk("rst.cs", 64'(bus.cs), 64'(1));
    chk("rst.sclk", 64'(bus.sclk), 64'(1));
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.valid", 64'(bus.valid), 64'(0));
    chk("rst.sample", 64'(bus.sample), 64'(0));
    chk("rst.lead_err", 64'(bus.lead_err), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);

    // single shot, then busy through QUIET
    adc_word = {1'b0, 12'd1100};
    pulse_start();
    chk("single.busy_on", 64'(bus.busy), 64'(1));
    chk("single.cs_low", 64'(bus.cs), 64'(0));
    wait_frame("single", r);
    chk_frame("single", r, 12'd1100, 1'b0);
    tick(QN - 1);
    chk("single.busy_quiet", 64'(bus.busy), 64'(1));
    tick(1);
    chk("single.busy_off", 64'(bus.busy), 64'(0));
    tick(PERIOD);
    chk("single.no_extra", 64'(recs.size()), 64'(0));

    // random single shots
    for (int i = 0; i < 4; i++) begin
      d  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      ld = 1'($urandom_range(0, 1));
      adc_word = {ld, d};
      pulse_start();
      wait_frame("rand", r);
      chk_frame("rand", r, d, ld);
      tick(QN + 2);
    end

    // lead error then clean frame
    adc_word = {1'b1, 12'd900};
    pulse_start();
    wait_frame("lead", r);
    chk_frame("lead", r, 12'd900, 1'b1);
    tick(QN + 2);
    d = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    adc_word = {1'b0, d};
    pulse_start();
    wait_frame("clean", r);
    chk_frame("clean", r, d, 1'b0);
    tick(QN + 2);

    // start while busy is ignored
    adc_word = {1'b0, 12'd2048};
    pulse_start();
    tick(20);
    pulse_start();
    wait_frame("ignore", r);
    chk_frame("ignore", r, 12'd2048, 1'b0);
    tick(3);
    pulse_start();
    tick(2 * PERIOD);
    chk("ignore.count", 64'(recs.size()), 64'(0));
    chk("ignore.idle", 64'(bus.busy), 64'(0));

    // free run alternating 1100 / 900
    adc_word = {1'b0, 12'd1100};
    exp_q.push_back(12'd1100);
    @(negedge clk);
    bus.free_run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_frame("free", r);
      d = (i % 2 == 0) ? 12'd900 : 12'd1100;
      adc_word = {1'b0, d};
      exp_q.push_back(d);
      chk_frame("free", r, exp_q.pop_front(), 1'b0);
      if (i > 0) begin
        chk("free.period", 64'(r.cyc - prev.cyc), 64'(PERIOD));
        chk("free.cs_gap", 64'(r.gap), 64'(GAP));
      end
      prev = r;
    end

    // drop free_run mid-frame
    tick(GAP + 20);
    chk("drop.busy", 64'(bus.busy), 64'(1));
    bus.free_run = 1'b0;
    wait_frame("drop", r);
    chk_frame("drop", r, exp_q.pop_front(), 1'b0);
    e0 = edges;
    tick(2 * PERIOD);
    chk("drop.count", 64'(recs.size()), 64'(0));
    chk("drop.cs", 64'(bus.cs), 64'(1));
    chk("drop.edges", 64'(edges - e0), 64'(0));
    chk("drop.busy_off", 64'(bus.busy), 64'(0));

    // asynchronous reset mid-SHIFT
    adc_word = {1'b0, 12'd777};
    pulse_start();
    tick(20);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst.cs", 64'(bus.cs), 64'(1));
    chk("arst.sclk", 64'(bus.sclk), 64'(1));
    chk("arst.busy", 64'(bus.busy), 64'(0));
    chk("arst.valid", 64'(bus.valid), 64'(0));
    tick(3);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2 * PERIOD);
    chk("arst.no_valid", 64'(recs.size()), 64'(0));
    d = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    adc_word = {1'b0, d};
    pulse_start();
    wait_frame("post_rst", r);
    chk_frame("post_rst", r, d, 1'b0);
    tick(QN + 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
